// File: rtl/serial_decode_execute.sv
// serial_decode_execute: bit-serial decode/execute unit built on a single
// full-adder slice.  Accepts op/rs/rt over a valid/ready handshake, spends
// WIDTH cycles in EXEC producing one result bit per clock (LSB first), then
// presents result/flags in DONE until out_ready is seen.
// Ports: clk, rst (async, active-high), in_valid/in_ready, op[2:0],
//   rs/rt[WIDTH-1:0], out_valid/out_ready, result[WIDTH-1:0],
//   flag_c/flag_v/flag_z.
// Optional: define SERIAL_EXE_FLAGS_EN to register the flags; otherwise
//   the flag ports are tied to 0.
module serial_decode_execute #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             is_logic;
    logic             is_slt;
    logic [3:0]       fn;

    logic [WIDTH-1:0] b_dec;
    logic             cin_dec;
    logic             logic_dec;
    logic             slt_dec;
    logic [3:0]       fn_dec;

    logic             accept;
    logic             last;
    logic             a_bit, b_bit;
    logic             sum, cout;
    logic             lbit, bit_out;
    logic             v_next;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_res;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Decode of the incoming opcode; latched only on accept.
    always_comb begin
        b_dec     = rt;
        cin_dec   = 1'b0;
        logic_dec = 1'b0;
        slt_dec   = 1'b0;
        fn_dec    = 4'b0000;
        unique case (op)
            3'b000: ;
            3'b001: begin
                b_dec   = ~rt;
                cin_dec = 1'b1;
            end
            3'b010: begin
                logic_dec = 1'b1;
                fn_dec    = 4'b0001;
            end
            3'b011: begin
                logic_dec = 1'b1;
                fn_dec    = 4'b0010;
            end
            3'b100: begin
                logic_dec = 1'b1;
                fn_dec    = 4'b0100;
            end
            3'b101: begin
                logic_dec = 1'b1;
                fn_dec    = 4'b1000;
            end
            3'b110: begin
                b_dec   = '0;
                cin_dec = 1'b1;
            end
            3'b111: begin
                b_dec   = ~rt;
                cin_dec = 1'b1;
                slt_dec = 1'b1;
            end
        endcase
    end

    // One full-adder slice plus per-bit logic gates.
    always_comb begin
        a_bit = a_sh[0];
        b_bit = b_sh[0];
        sum   = a_bit ^ b_bit ^ carry;
        cout  = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
        lbit  = 1'b0;
        unique case (1'b1)
            fn[0]:   lbit = a_bit & b_bit;
            fn[1]:   lbit = a_bit | b_bit;
            fn[2]:   lbit = a_bit ^ b_bit;
            fn[3]:   lbit = ~a_bit;
            default: lbit = 1'b0;
        endcase
        bit_out  = is_logic ? lbit : sum;
        res_next = {bit_out, res_sh[WIDTH-1:1]};
        // On the MSB step, carry holds the carry into the MSB.
        v_next   = is_logic ? 1'b0 : (carry ^ cout);
        if (is_slt)
            final_res = {{(WIDTH-1){1'b0}}, sum ^ v_next};
        else
            final_res = res_next;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            res_q    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            is_logic <= 1'b0;
            is_slt   <= 1'b0;
            fn       <= 4'b0000;
        end else if (state == IDLE) begin
            if (accept) begin
                a_sh     <= rs;
                b_sh     <= b_dec;
                res_sh   <= '0;
                carry    <= cin_dec;
                cnt      <= '0;
                is_logic <= logic_dec;
                is_slt   <= slt_dec;
                fn       <= fn_dec;
            end
        end else if (state == EXEC) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= cout;
            cnt    <= cnt + 1'b1;
            if (last)
                res_q <= final_res;
        end
    end

    assign result = res_q;

`ifdef SERIAL_EXE_FLAGS_EN
    logic fc_q, fv_q, fz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= 1'b0;
            fv_q <= 1'b0;
            fz_q <= 1'b0;
        end else if (state == EXEC && last) begin
            fc_q <= is_logic ? 1'b0 : cout;
            fv_q <= v_next;
            fz_q <= (final_res == '0);
        end
    end

    assign flag_c = fc_q;
    assign flag_v = fv_q;
    assign flag_z = fz_q;
`else
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
    assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_serial_decode_execute.sv
// Directed self-checking bench for serial_decode_execute (WIDTH=8).
// Flag expectations collapse to 0 when SERIAL_EXE_FLAGS_EN is undefined.
module tb_serial_decode_execute;

    localparam int W = 8;

`ifdef SERIAL_EXE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         flag_c, flag_v, flag_z;

    int errors = 0;
    int checks = 0;

    serial_decode_execute #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, wait for out_valid.
    // Latency n counts negedges after the accept edge; the first high
    // sample before edge k+9 gives n=9.
    task automatic run(input string tag, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec,
                       input logic ev, input logic ez);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op = o;
        rs = a;
        rt = b;
        @(negedge clk);
        in_valid = 1'b0;
        op = ~o;
        rs = ~a;
        rt = ~b;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_result"}, result, er);
        chk({tag, "_c"}, flag_c, FL & ec);
        chk({tag, "_v"}, flag_v, FL & ev);
        chk({tag, "_z"}, flag_z, FL & ez);
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_ov_drop"}, out_valid, 0);
            chk({tag, "_rdy_back"}, in_ready, 1);
        end
    endtask

    initial begin
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_c, flag_v, flag_z}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        run("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 0, 1, 0);
        run("sub_05_07", 3'b001, 8'h05, 8'h07, 8'hFE, 0, 0, 0);
        run("sub_07_07", 3'b001, 8'h07, 8'h07, 8'h00, 1, 0, 1);
        run("slt_80_01", 3'b111, 8'h80, 8'h01, 8'h01, 1, 1, 0);
        run("slt_01_80", 3'b111, 8'h01, 8'h80, 8'h00, 0, 1, 1);
        run("and",       3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
        run("or",        3'b011, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0);
        run("xor",       3'b100, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0);
        run("not",       3'b101, 8'hF0, 8'h3C, 8'h0F, 0, 0, 0);
        run("inc_ff",    3'b110, 8'hFF, 8'h5A, 8'h00, 1, 0, 1);

        // Backpressure in DONE with an in_valid pulse that must be ignored.
        out_ready = 1'b0;
        run("bp_add", 3'b000, 8'h40, 8'h40, 8'h80, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            op = 3'b000;
            rs = 8'h01;
            rt = 8'h01;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 8'h80);
            chk("bp_flags", {flag_c, flag_v, flag_z}, {1'b0, FL, 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ov", out_valid, 0);
        chk("bp_rel_rdy", in_ready, 1);
        repeat (12) @(negedge clk);
        chk("bp_no_phantom", out_valid, 0);
        chk("bp_held_result", result, 8'h80);

        // Reset during the third EXEC cycle.
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'b000;
        rs = 8'h12;
        rt = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", in_ready, 1);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_ov", out_valid, 0);

        run("add_12_34", 3'b000, 8'h12, 8'h34, 8'h46, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
